// File: rtl/arm_ctrl_pkg.sv
// Shared types and instruction field positions for the ARM operand-fetch control path.
package arm_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RS   = 2'd1,
    S_OUT  = 2'd2
  } shift_ctrl_state_t;

  localparam int unsigned INST_W = 32;
  localparam int unsigned RN_HI  = 19;
  localparam int unsigned RN_LO  = 16;
  localparam int unsigned RM_HI  = 3;
  localparam int unsigned RM_LO  = 0;
  localparam int unsigned RS_HI  = 11;
  localparam int unsigned RS_LO  = 8;

endpackage

// File: rtl/arm_shift_decode.sv
// Combinational decode of register-shift need and Rn/Rm/Rs fields; shared with the barrel-shift path.
module arm_shift_decode
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic [INST_W-1:0] inst,
  output logic              needs_rs,
  output logic [AW-1:0]     rn,
  output logic [AW-1:0]     rm,
  output logic [AW-1:0]     rs
);

  // Data-processing, register operand, shift amount taken from Rs.
  always_comb begin
    needs_rs = (inst[27:26] == 2'b00) && !inst[25] && inst[4] && !inst[7];
    rn       = AW'(inst[RN_HI:RN_LO]);
    rm       = AW'(inst[RM_HI:RM_LO]);
    rs       = AW'(inst[RS_HI:RS_LO]);
  end

endmodule

// File: rtl/arm_shift_operand_ctrl.sv
// Sequences two-port register-file reads into an Rn/Rm/Rs operand bundle for the shift/ALU stage.
// Optional ARM_RS_BYPASS_EN: reuse the Rn/Rm read for Rs when the register numbers match.
module arm_shift_operand_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst,
  output logic              inst_ready,
  output logic [AW-1:0]     rf_rd_addr1,
  output logic [AW-1:0]     rf_rd_addr2,
  input  logic [DW-1:0]     rf_rd_data1,
  input  logic [DW-1:0]     rf_rd_data2,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [INST_W-1:0] op_inst,
  output logic [DW-1:0]     op_rn,
  output logic [DW-1:0]     op_rm,
  output logic [DW-1:0]     op_rs
);

  shift_ctrl_state_t state, state_nxt;
  logic              needs_rs;
  logic [AW-1:0]     dec_rn, dec_rm, dec_rs, cap_rs;
  logic              accept, bypass_rn, bypass_rm;

  arm_shift_decode #(.AW(AW)) u_decode (
    .inst     (inst),
    .needs_rs (needs_rs),
    .rn       (dec_rn),
    .rm       (dec_rm),
    .rs       (dec_rs)
  );

  assign cap_rs = AW'(op_inst[RS_HI:RS_LO]);

  // Next state, accept handshake and read-port steering.
  always_comb begin
    state_nxt   = state;
    inst_ready  = 1'b0;
    rf_rd_addr1 = '0;
    rf_rd_addr2 = '0;
    bypass_rn   = 1'b0;
    bypass_rm   = 1'b0;
    case (state)
      S_IDLE: begin
        inst_ready  = 1'b1;
        rf_rd_addr1 = dec_rn;
        rf_rd_addr2 = dec_rm;
      end
      S_RS: begin
        rf_rd_addr1 = cap_rs;
        state_nxt   = S_OUT;
      end
      S_OUT: begin
        if (op_ready) begin
          inst_ready  = 1'b1;
          rf_rd_addr1 = dec_rn;
          rf_rd_addr2 = dec_rm;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) inst_ready = 1'b0;
    accept = inst_valid && inst_ready;
`ifdef ARM_RS_BYPASS_EN
    bypass_rn = needs_rs && (dec_rs == dec_rn);
    bypass_rm = needs_rs && !bypass_rn && (dec_rs == dec_rm);
`else
    bypass_rn = 1'b0;
    bypass_rm = 1'b0;
`endif
    if (accept) state_nxt = (needs_rs && !bypass_rn && !bypass_rm) ? S_RS : S_OUT;
    if (flush) state_nxt = S_IDLE;
  end

  // State and registered operand bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_valid <= 1'b0;
      op_inst  <= '0;
      op_rn    <= '0;
      op_rm    <= '0;
      op_rs    <= '0;
    end else begin
      state    <= state_nxt;
      op_valid <= (state_nxt == S_OUT);
      if (accept) begin
        op_inst <= inst;
        op_rn   <= rf_rd_data1;
        op_rm   <= rf_rd_data2;
        op_rs   <= bypass_rn ? rf_rd_data1 : (bypass_rm ? rf_rd_data2 : '0);
      end else if (state == S_RS && !flush) begin
        op_rs <= rf_rd_data1;
      end
    end
  end

endmodule

// File: tb/tb_arm_shift_operand_ctrl.sv
// Directed bench for arm_shift_operand_ctrl: vector table plus backpressure, flush and reset sequences.
module tb_arm_shift_operand_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
`ifdef ARM_RS_BYPASS_EN
  localparam int BYP_LAT = 1;
`else
  localparam int BYP_LAT = 2;
`endif

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] rs;
    int          lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, flush, inst_valid, op_ready;
  logic [31:0]   inst;
  logic          inst_ready, op_valid;
  logic [AW-1:0] rf_rd_addr1, rf_rd_addr2;
  logic [DW-1:0] rf_rd_data1, rf_rd_data2;
  logic [31:0]   op_inst;
  logic [DW-1:0] op_rn, op_rm, op_rs;

  logic [DW-1:0] rf [16];
  int            n_cmp = 0;
  int            n_err = 0;
  vec_t          vecs [8];

  assign rf_rd_data1 = rf[rf_rd_addr1];
  assign rf_rd_data2 = rf[rf_rd_addr2];

  always #5 clk = ~clk;

  arm_shift_operand_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_ready  (inst_ready),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_inst     (op_inst),
    .op_rn       (op_rn),
    .op_rm       (op_rm),
    .op_rs       (op_rs)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int            cyc;
    logic [31:0]   h_inst, h_rn, h_rm, h_rs;

    for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hA0; rf[1] = 32'd5; rf[2] = 32'd7; rf[3] = 32'd4;
    rf[5] = 32'h55; rf[15] = 32'hF0F0;

    vecs[0] = '{"imm_shift",   32'hE0810102, 32'd5, 32'd7,  32'd0,      1};
    vecs[1] = '{"reg_shift",   32'hE0810312, 32'd5, 32'd7,  32'd4,      2};
    vecs[2] = '{"immediate",   32'hE2810005, 32'd5, 32'h55, 32'd0,      1};
    vecs[3] = '{"bit7_set",    32'hE0810392, 32'd5, 32'd7,  32'd0,      1};
    vecs[4] = '{"rs_r15",      32'hE0810F12, 32'd5, 32'd7,  32'hF0F0,   2};
    vecs[5] = '{"ldr",         32'hE5910000, 32'd5, 32'hA0, 32'd0,      1};
    vecs[6] = '{"rs_eq_rn",    32'hE0810112, 32'd5, 32'd7,  32'd5,      BYP_LAT};
    vecs[7] = '{"rs_eq_rm",    32'hE0810212, 32'd5, 32'd7,  32'd7,      BYP_LAT};

    rst = 1'b1; flush = 1'b0; inst_valid = 1'b0; op_ready = 1'b1; inst = 32'h0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op_inst", op_inst, 32'd0);
    check("rst_op_rn", op_rn, 32'd0);
    check("rst_op_rm", op_rm, 32'd0);
    check("rst_op_rs", op_rs, 32'd0);
    check("rst_inst_ready", 32'(inst_ready), 32'd1);

    // Table-driven single instructions with op_ready high.
    foreach (vecs[i]) begin
      inst = vecs[i].inst; inst_valid = 1'b1; op_ready = 1'b1;
      #1;
      check({vecs[i].name, "_ready_idle"}, 32'(inst_ready), 32'd1);
      check({vecs[i].name, "_addr1"}, 32'(rf_rd_addr1), 32'(vecs[i].inst[19:16]));
      step();
      inst_valid = 1'b0;
      #1;
      cyc = 1;
      if (vecs[i].lat == 2) begin
        check({vecs[i].name, "_rs_ready"}, 32'(inst_ready), 32'd0);
        check({vecs[i].name, "_rs_addr1"}, 32'(rf_rd_addr1), 32'(vecs[i].inst[11:8]));
      end
      while (!op_valid && cyc < 6) begin
        step();
        cyc++;
      end
      check({vecs[i].name, "_latency"}, 32'(cyc), 32'(vecs[i].lat));
      check({vecs[i].name, "_op_inst"}, op_inst, vecs[i].inst);
      check({vecs[i].name, "_op_rn"}, op_rn, vecs[i].rn);
      check({vecs[i].name, "_op_rm"}, op_rm, vecs[i].rm);
      check({vecs[i].name, "_op_rs"}, op_rs, vecs[i].rs);
      check({vecs[i].name, "_ready_out"}, 32'(inst_ready), 32'd1);
      step();
      check({vecs[i].name, "_drain"}, 32'(op_valid), 32'd0);
    end

    // Backpressure then back-to-back accept without a bubble.
    op_ready = 1'b0; inst = 32'hE0810312; inst_valid = 1'b1;
    step(); inst_valid = 1'b0; step();
    check("bp_valid", 32'(op_valid), 32'd1);
    h_inst = op_inst; h_rn = op_rn; h_rm = op_rm; h_rs = op_rs;
    inst = 32'hE2810005; inst_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_valid", 32'(op_valid), 32'd1);
      check("bp_hold_inst", op_inst, h_inst);
      check("bp_hold_rs", op_rs, h_rs);
      check("bp_hold_rn_rm", op_rn ^ op_rm, h_rn ^ h_rm);
      check("bp_inst_ready", 32'(inst_ready), 32'd0);
    end
    op_ready = 1'b1;
    #1;
    check("b2b_inst_ready", 32'(inst_ready), 32'd1);
    step();
    inst_valid = 1'b0;
    #1;
    check("b2b_valid", 32'(op_valid), 32'd1);
    check("b2b_op_inst", op_inst, 32'hE2810005);
    check("b2b_op_rm", op_rm, 32'h55);
    check("b2b_op_rs", op_rs, 32'd0);
    step();

    // Flush while in S_RS, with a new instruction offered.
    inst = 32'hE0810312; inst_valid = 1'b1;
    step();
    inst = 32'hE0810102; flush = 1'b1;
    #1;
    check("flush_rs_ready", 32'(inst_ready), 32'd0);
    step();
    flush = 1'b0; inst_valid = 1'b0;
    #1;
    check("flush_rs_valid", 32'(op_valid), 32'd0);
    check("flush_idle_ready", 32'(inst_ready), 32'd1);
    step();
    check("flush_rs_stay", 32'(op_valid), 32'd0);

    // Flush in S_IDLE must block the accept.
    inst_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; inst_valid = 1'b0;
    #1;
    check("flush_idle_valid", 32'(op_valid), 32'd0);
    step();
    check("flush_idle_stay", 32'(op_valid), 32'd0);

    // Reset while holding in S_OUT.
    op_ready = 1'b0; inst = 32'hE0810312; inst_valid = 1'b1;
    step(); inst_valid = 1'b0; step();
    check("rst_out_pre_valid", 32'(op_valid), 32'd1);
    check("rst_out_pre_rs", op_rs, 32'd4);
    rst = 1'b1;
    step();
    check("rst_out_valid", 32'(op_valid), 32'd0);
    check("rst_out_inst", op_inst, 32'd0);
    check("rst_out_rn", op_rn, 32'd0);
    check("rst_out_rm", op_rm, 32'd0);
    check("rst_out_rs", op_rs, 32'd0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
